vehicle_sensor_conditioner: RTL and testbench

//   Upstream stage of trafficLightController. Takes raw, asynchronous inductive-loop detector levels for the

---
 rtl/vehicle_sensor_conditioner_if.sv | 25 ++
 rtl/vehicle_sensor_conditioner.sv | 150 +++++++++++++++
 tb/tb_vehicle_sensor_conditioner.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vehicle_sensor_conditioner_if.sv
// Loop-detector bundle between the raw loop inputs and the conditioned
// sensor/fault outputs consumed by trafficLightController.
interface vehicle_sensor_conditioner_if;
  logic [3:0] raw_1th;
  logic [3:0] raw_5th;
  logic [3:0] sensor_1th;
  logic [3:0] sensor_5th;
  logic [3:0] fault;

  modport master (
    output raw_1th,
    output raw_5th,
    input  sensor_1th,
    input  sensor_5th,
    input  fault
  );

  modport slave (
    input  raw_1th,
    input  raw_5th,
    output sensor_1th,
    output sensor_5th,
    output fault
  );
endinterface

// File: rtl/vehicle_sensor_conditioner.sv
// Vehicle sensor conditioner: synchronises and debounces the eight raw
// inductive-loop levels (4 lanes x {1st-car, 5th-car}), gates queue presence
// by 1st-car presence and latches a sticky per-lane fault when a queue loop
// stays on without its 1st-car loop.
// Channel map: ch 0..3 = 1th lanes N,S,E,W; ch 4..7 = 5th lanes N,S,E,W.
module vehicle_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RELEASE_CYCLES  = 8,
  parameter int FAULT_CYCLES    = 32,
  parameter int CNT_W           = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  vehicle_sensor_conditioner_if.slave  bus
);

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } deb_state_t;

  localparam logic [CNT_W:0] DEB_TERM = (CNT_W+1)'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W:0] REL_TERM = (CNT_W+1)'(RELEASE_CYCLES);
  localparam logic [CNT_W:0] FLT_TERM = (CNT_W+1)'(FAULT_CYCLES);

  // True when one more count reaches the terminal value.
  function automatic logic hits_term(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W:0]   term);
    return ({1'b0, v} + (CNT_W+1)'(1)) == term;
  endfunction

  // Saturating increment: a counter never wraps back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [7:0]       sync_p0;
  logic [7:0]       sync_p1;
  deb_state_t       state_p2 [8];
  logic [CNT_W-1:0] cnt_p2   [8];
  logic [CNT_W-1:0] fcnt_p2  [4];
  logic [3:0]       fault_p2;

  deb_state_t       state_nxt [8];
  logic [CNT_W-1:0] cnt_nxt   [8];
  logic [CNT_W-1:0] fcnt_nxt  [4];
  logic [3:0]       fault_nxt;
  logic [7:0]       deb;

  // --- stage p0/p1: two-flop synchroniser for the asynchronous loop levels
  // Capture raw levels through two flops per channel to tame metastability.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {bus.raw_5th, bus.raw_1th};
      sync_p1 <= sync_p0;
    end
  end

  // --- stage p2: debounce state, counters and sticky fault
  // State register for all debounce FSMs and the lane fault trackers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < 8; ch++) begin
        state_p2[ch] <= ST_OFF;
        cnt_p2[ch]   <= '0;
      end
      for (int ln = 0; ln < 4; ln++) begin
        fcnt_p2[ln] <= '0;
      end
      fault_p2 <= '0;
    end else begin
      for (int ch = 0; ch < 8; ch++) begin
        state_p2[ch] <= state_nxt[ch];
        cnt_p2[ch]   <= cnt_nxt[ch];
      end
      for (int ln = 0; ln < 4; ln++) begin
        fcnt_p2[ln] <= fcnt_nxt[ln];
      end
      fault_p2 <= fault_nxt;
    end
  end

  // Debounced level of each channel, decoded from its FSM state.
  always_comb begin
    deb = '0;
    for (int ch = 0; ch < 8; ch++) begin
      deb[ch] = (state_p2[ch] == ST_ON);
    end
  end

  // Hysteretic debounce: any opposing sample restarts the run counter.
  always_comb begin
    for (int ch = 0; ch < 8; ch++) begin
      state_nxt[ch] = state_p2[ch];
      cnt_nxt[ch]   = cnt_p2[ch];
      case (state_p2[ch])
        ST_OFF: begin
          if (!sync_p1[ch]) begin
            cnt_nxt[ch] = '0;
          end else if (hits_term(cnt_p2[ch], DEB_TERM)) begin
            state_nxt[ch] = ST_ON;
            cnt_nxt[ch]   = '0;
          end else begin
            cnt_nxt[ch] = sat_inc(cnt_p2[ch]);
          end
        end
        ST_ON: begin
          if (sync_p1[ch]) begin
            cnt_nxt[ch] = '0;
          end else if (hits_term(cnt_p2[ch], REL_TERM)) begin
            state_nxt[ch] = ST_OFF;
            cnt_nxt[ch]   = '0;
          end else begin
            cnt_nxt[ch] = sat_inc(cnt_p2[ch]);
          end
        end
        default: begin
          state_nxt[ch] = ST_OFF;
          cnt_nxt[ch]   = '0;
        end
      endcase
    end
  end

  // Fault tracking: queue loop on while 1st-car loop off for too long.
  // Once the terminal count is reached the counter holds there.
  always_comb begin
    fault_nxt = fault_p2;
    for (int ln = 0; ln < 4; ln++) begin
      fcnt_nxt[ln] = '0;
      if (deb[4+ln] && !deb[ln]) begin
        if (hits_term(fcnt_p2[ln], FLT_TERM)) begin
          fault_nxt[ln] = 1'b1;
          fcnt_nxt[ln]  = fcnt_p2[ln];
        end else begin
          fcnt_nxt[ln] = sat_inc(fcnt_p2[ln]);
        end
      end
    end
  end

  // Outputs straight from debounce state; a faulted lane hides its queue.
  assign bus.sensor_1th = deb[3:0];
  assign bus.sensor_5th = deb[7:4] & deb[3:0] & ~fault_p2;
  assign bus.fault      = fault_p2;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed bench for vehicle_sensor_conditioner with hand-computed results.
// Inputs change #1 after a rising edge; outputs are checked at that point,
// so after tick(n) the outputs reflect edge n counted from the last change.
module tb_vehicle_sensor_conditioner;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  vehicle_sensor_conditioner_if bus ();

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .RELEASE_CYCLES  (8),
    .FAULT_CYCLES    (32),
    .CNT_W           (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got,
                          input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clean_reset();
    rst = 1'b0;
    bus.raw_1th = 4'h0;
    bus.raw_5th = 4'h0;
    tick(2);
    rst = 1'b1;
  endtask

  initial begin
    logic [11:0] glitch_seq;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.raw_1th = 4'hF;
    bus.raw_5th = 4'hF;

    // T1: reset holds all outputs low even with every loop active
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("t1_rst_s1", bus.sensor_1th, 4'h0);
      check_eq("t1_rst_s5", bus.sensor_5th, 4'h0);
      check_eq("t1_rst_flt", bus.fault, 4'h0);
    end
    rst = 1'b1;
    tick(1);
    check_eq("t1_rel1_s1", bus.sensor_1th, 4'h0);
    tick(4);
    check_eq("t1_rel5_s1", bus.sensor_1th, 4'h0);
    check_eq("t1_rel5_s5", bus.sensor_5th, 4'h0);
    tick(1);
    check_eq("t1_rel6_s1", bus.sensor_1th, 4'hF);
    check_eq("t1_rel6_s5", bus.sensor_5th, 4'hF);
    check_eq("t1_rel6_flt", bus.fault, 4'h0);

    // T2: assert after 6 edges, release after 10 edges
    clean_reset();
    bus.raw_1th = 4'b0001;
    tick(5);
    check_eq("t2_rise5", bus.sensor_1th, 4'b0000);
    tick(1);
    check_eq("t2_rise6", bus.sensor_1th, 4'b0001);
    bus.raw_1th = 4'b0000;
    tick(9);
    check_eq("t2_fall9", bus.sensor_1th, 4'b0001);
    tick(1);
    check_eq("t2_fall10", bus.sensor_1th, 4'b0000);

    // T3: 3-high / 1-low / 3-high never asserts; a 4-cycle hold does
    clean_reset();
    glitch_seq = 12'b0000_0111_0111;
    for (int i = 0; i < 12; i++) begin
      bus.raw_1th = {1'b0, glitch_seq[i], 2'b00};
      tick(1);
      check_eq("t3_glitch", bus.sensor_1th, 4'b0000);
    end
    bus.raw_1th = 4'b0100;
    tick(5);
    check_eq("t3_hold5", bus.sensor_1th, 4'b0000);
    tick(1);
    check_eq("t3_hold6", bus.sensor_1th, 4'b0100);

    // T4: queue presence gated by 1st-car presence
    clean_reset();
    bus.raw_1th = 4'b0011;
    bus.raw_5th = 4'b0010;
    tick(6);
    check_eq("t4_s1", bus.sensor_1th, 4'b0011);
    check_eq("t4_s5", bus.sensor_5th, 4'b0010);
    bus.raw_1th = 4'b0001;
    tick(9);
    check_eq("t4_pre_s5", bus.sensor_5th, 4'b0010);
    tick(1);
    check_eq("t4_drop_s1", bus.sensor_1th, 4'b0001);
    check_eq("t4_drop_s5", bus.sensor_5th, 4'b0000);

    // T5: west queue loop alone for 32 debounced cycles latches a fault
    clean_reset();
    bus.raw_5th = 4'b1000;
    tick(37);
    check_eq("t5_flt37", bus.fault, 4'b0000);
    check_eq("t5_s5_37", bus.sensor_5th, 4'b0000);
    tick(1);
    check_eq("t5_flt38", bus.fault, 4'b1000);
    bus.raw_1th = 4'b1000;
    tick(6);
    check_eq("t5_faulted_s1", bus.sensor_1th, 4'b1000);
    check_eq("t5_faulted_s5", bus.sensor_5th, 4'b0000);
    bus.raw_1th = 4'b0000;
    bus.raw_5th = 4'b0000;
    tick(15);
    check_eq("t5_sticky", bus.fault, 4'b1000);
    rst = 1'b0;
    tick(1);
    check_eq("t5_clear", bus.fault, 4'b0000);
    rst = 1'b1;

    // T6: one-cycle reset mid-operation, then reassert 6 edges later
    clean_reset();
    bus.raw_1th = 4'hF;
    bus.raw_5th = 4'hF;
    tick(6);
    check_eq("t6_on_s1", bus.sensor_1th, 4'hF);
    check_eq("t6_on_s5", bus.sensor_5th, 4'hF);
    rst = 1'b0;
    tick(1);
    check_eq("t6_rst_s1", bus.sensor_1th, 4'h0);
    check_eq("t6_rst_s5", bus.sensor_5th, 4'h0);
    rst = 1'b1;
    tick(5);
    check_eq("t6_re5_s1", bus.sensor_1th, 4'h0);
    tick(1);
    check_eq("t6_re6_s1", bus.sensor_1th, 4'hF);
    check_eq("t6_re6_s5", bus.sensor_5th, 4'hF);
    check_eq("t6_re6_flt", bus.fault, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
